// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory / MMIO unit.
// Holds the MMIO window base, the register offsets and the TX_STATUS layout.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE     = 32'hFFFF_FF00;
  localparam logic [7:0]  OFF_TX_DATA   = 8'h00;
  localparam logic [7:0]  OFF_TX_STATUS = 8'h01;
  localparam logic [7:0]  OFF_CYCLE     = 8'h02;
  localparam logic [7:0]  OFF_CYCLE_CLR = 8'h03;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_MMIO = 2'd2
  } region_e;

  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic ovf,
                                              input logic full, input logic empty);
    logic [31:0] s;
    s = 32'd0;
    s[ST_CNT_LSB +: 8] = cnt;
    s[ST_OVF]          = ovf;
    s[ST_FULL]         = full;
    s[ST_EMPTY]        = empty;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push is accepted while full
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with a small MMIO window: word RAM, TX FIFO, cycle counter and
// sticky overflow flag. Loads are combinational from addr for same-cycle capture.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  output logic [31:0] rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [2**ADDR_W];
  logic [31:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;
  region_e       region_s;
  logic [7:0]    off_s;
  logic          ram_we_s, tx_push_s, tx_pop_s, push_rej_s, ovf_clr_s, cyc_clr_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;

  assign off_s = addr[7:0];

  always_comb begin
    region_s = REG_NONE;
    if (addr[31:ADDR_W] == '0) begin
      region_s = REG_RAM;
    end else if (addr[31:8] == MMIO_BASE[31:8]) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_NONE;
    end
  end

  // MMIO side effects are suppressed in a reset cycle; RAM stores still land.
  assign ram_we_s   = memwrite & (region_s == REG_RAM);
  assign tx_push_s  = memwrite & ~rst & (region_s == REG_MMIO) & (off_s == OFF_TX_DATA);
  assign ovf_clr_s  = memwrite & (region_s == REG_MMIO) & (off_s == OFF_TX_STATUS) & wdata[2];
  assign cyc_clr_s  = memwrite & (region_s == REG_MMIO) & (off_s == OFF_CYCLE_CLR);
  assign tx_pop_s   = tx_valid & tx_ready;
  assign push_rej_s = tx_push_s & fifo_full_s & ~tx_pop_s;
  assign cycle_d    = cyc_clr_s ? 32'd0 : cycle_q + 32'd1;
  assign tx_valid   = ~fifo_empty_s;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push_s),
    .pop_i   (tx_pop_s),
    .wdata_i (wdata),
    .rdata_o (tx_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Set beats clear when both occur together.
  always_comb begin
    ovf_d = ovf_q;
    if (push_rej_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      cycle_q <= 32'd0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[addr[ADDR_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (region_s)
      REG_RAM:  rdata = ram_q[addr[ADDR_W-1:0]];
      REG_MMIO: begin
        case (off_s)
          OFF_TX_STATUS: rdata = pack_status(8'(fifo_count_s), ovf_q, fifo_full_s, fifo_empty_s);
          OFF_CYCLE:     rdata = cycle_q;
          default:       rdata = 32'd0;
        endcase
      end
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: a driver issues one transaction per cycle and
// queues the expected outputs from a queue/array reference model; a monitor checks them.
module tb_dmem_mmio;

  localparam logic [31:0] TXD = 32'hFFFF_FF00;
  localparam logic [31:0] STS = 32'hFFFF_FF01;
  localparam logic [31:0] CYC = 32'hFFFF_FF02;
  localparam logic [31:0] CLR = 32'hFFFF_FF03;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        memwrite = 1'b0;
  logic [31:0] rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  dmem_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .memwrite (memwrite),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          chk_rd;
    logic [31:0] rd;
    bit          txv;
    logic [31:0] txd;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  // Reference model state
  logic [31:0] m_mem [1024];
  bit          m_wr  [1024];
  logic [31:0] m_fifo[$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_cyc = 32'd0;
  bit          m_force = 1'b0;
  bit          en_chk = 1'b0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int n;
    n = m_fifo.size();
    if ((a >> 10) == 32'd0) return m_mem[a[9:0]];
    if (a[31:8] != 24'hFFFFFF) return 32'd0;
    if (a[7:0] == 8'h01) return (n << 8) | (m_ovf ? 32'd4 : 32'd0) | ((n == 4) ? 32'd2 : 32'd0) | ((n == 0) ? 32'd1 : 32'd0);
    if (a[7:0] == 8'h02) return m_cyc;
    return 32'd0;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endfunction

  task automatic step(input bit r, input logic [31:0] a, input logic [31:0] d, input bit w,
                      input bit rdy, input bit c, input string nm);
    exp_t e;
    int   n0;
    bit   pop;
    bit   mmio;
    rst = r; addr = a; wdata = d; memwrite = w; tx_ready = rdy;
    e.en = en_chk; e.chk_rd = c; e.rd = model_rd(a); e.name = nm;
    e.txv = (m_fifo.size() != 0);
    e.txd = e.txv ? m_fifo[0] : 32'd0;
    exp_q.push_back(e);
    n0   = m_fifo.size();
    pop  = (n0 != 0) && rdy;
    mmio = (a[31:8] == 24'hFFFFFF);
    if (w && (a >> 10) == 32'd0) begin
      m_mem[a[9:0]] = d;
      m_wr[a[9:0]]  = 1'b1;
    end
    if (r) begin
      m_fifo.delete();
      m_ovf = 1'b0;
      m_cyc = 32'd0;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (w && mmio && a[7:0] == 8'h01 && d[2]) m_ovf = 1'b0;
      if (w && mmio && a[7:0] == 8'h00) begin
        if (n0 < 4 || pop) m_fifo.push_back(d);
        else m_ovf = 1'b1;
      end
      if (m_force) m_cyc = 32'hFFFF_FFFF;
      else if (w && mmio && a[7:0] == 8'h03) m_cyc = 32'd0;
      else m_cyc = m_cyc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.en) begin
        if (e.chk_rd) check({e.name, " rdata"}, rdata, e.rd);
        check({e.name, " tx_valid"}, {31'd0, tx_valid}, {31'd0, e.txv});
        if (tx_valid && tx_ready) check({e.name, " tx_data"}, tx_data, e.txd);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    bit          w, c, r;
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = 32'd0;
      m_wr[i]  = 1'b0;
    end
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "rst0");
    en_chk = 1'b1;
    step(1'b1, STS, 32'd0, 1'b0, 1'b0, 1'b1, "rst_status");
    for (int i = 0; i < 11; i++) step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cycle_run");

    // RAM store/load ordering and decode holes
    step(1'b0, 32'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0, "ram_w0");
    step(1'b0, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, "ram_same_cycle_old");
    step(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, "ram_read_new");
    step(1'b0, 32'h0000_1000, 32'hAAAA_5555, 1'b1, 1'b0, 1'b1, "hole_write");
    step(1'b0, 32'h0000_1000, 32'd0, 1'b0, 1'b0, 1'b1, "hole_read");
    step(1'b0, 32'hFFFF_FF07, 32'd0, 1'b0, 1'b0, 1'b1, "mmio_hole");

    // Three pushes held, then drained back-to-back
    step(1'b0, TXD, 32'h11, 1'b1, 1'b0, 1'b1, "push11");
    step(1'b0, TXD, 32'h22, 1'b1, 1'b0, 1'b1, "push22");
    step(1'b0, TXD, 32'h33, 1'b1, 1'b0, 1'b1, "push33");
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "status3");
    for (int i = 0; i < 4; i++) step(1'b0, STS, 32'd0, 1'b0, 1'b1, 1'b1, "drain3");

    // Overflow on a full FIFO, then clear
    for (int i = 0; i < 4; i++) step(1'b0, TXD, 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b0, "fill");
    step(1'b0, TXD, 32'h55, 1'b1, 1'b0, 1'b1, "push_over");
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "status_ovf");
    step(1'b0, STS, 32'h4, 1'b1, 1'b0, 1'b1, "ovf_clr");
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "status_cleared");

    // Full with simultaneous pop and push
    step(1'b0, TXD, 32'h66, 1'b1, 1'b1, 1'b1, "full_push_pop");
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "status_full_nopvf");
    for (int i = 0; i < 5; i++) step(1'b0, STS, 32'd0, 1'b0, 1'b1, 1'b1, "drain4");

    // Cycle clear and wrap
    step(1'b0, CLR, 32'd0, 1'b1, 1'b0, 1'b1, "cyc_clr");
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_after_clr0");
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_after_clr1");
    force dut.cycle_d = 32'hFFFF_FFFF;
    m_force = 1'b1;
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_load_max");
    release dut.cycle_d;
    m_force = 1'b0;
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_max");
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_wrap");

    // Reset with entries queued and overflow set
    for (int i = 0; i < 4; i++) step(1'b0, TXD, 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0, "fill2");
    step(1'b0, TXD, 32'h77, 1'b1, 1'b0, 1'b0, "push_over2");
    step(1'b0, STS, 32'd0, 1'b0, 1'b1, 1'b1, "pop_a");
    step(1'b0, STS, 32'd0, 1'b0, 1'b1, 1'b1, "pop_b");
    step(1'b1, TXD, 32'h88, 1'b1, 1'b1, 1'b1, "rst_push");
    step(1'b1, 32'd7, 32'hCAFE_0007, 1'b1, 1'b0, 1'b0, "rst_ram_w");
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "status_after_rst");
    step(1'b0, CYC, 32'd0, 1'b0, 1'b0, 1'b1, "cyc_after_rst");
    step(1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, "ram_kept_in_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 15));
        1:       a = TXD + 32'($urandom_range(0, 5));
        2:       a = TXD;
        default: a = $urandom;
      endcase
      d = $urandom;
      w = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 63) == 0);
      c = ((a >> 10) == 32'd0) ? m_wr[a[9:0]] : 1'b1;
      step(r, a, d, w, ($urandom_range(0, 2) == 0), c, "random");
    end
    step(1'b0, STS, 32'd0, 1'b0, 1'b0, 1'b1, "final");

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory unit directly downstream of the core's MEM stage: consumes the registered ALU address, store data and store strobe, and returns load data combinationally in the same cycle for capture into MEM/WB. Contains a word-addressed RAM plus a small memory-mapped peripheral window: a transmit FIFO with a valid/ready output handshake, a free-running cycle counter and a sticky overflow flag.

## Interface
- ADDR_W, 10, RAM word-index width; RAM depth = 2**ADDR_W words
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  32  word address from MEM stage (alu_DMEM)
- wdata  in  32  store data (writedata_DMEM)
- memwrite  in  1  store strobe (memwrite_MEM)
- rdata  out  32  load data, combinational from addr (feeds readdata_MEM)
- tx_data  out  32  head-of-FIFO word
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts tx_data this cycle

## Operation
- Decode on addr: RAM if addr[31:ADDR_W]==0; MMIO if addr[31:8]==24'hFFFFFF; anything else reads 0, writes ignored.
- RAM: index addr[ADDR_W-1:0]; write on edge when memwrite; read asynchronous. Contents not affected by reset.
- MMIO offsets (addr[7:0]), others read 0 / ignore writes:
  - 0x00 TX_DATA: write pushes wdata; read returns 0.
  - 0x01 TX_STATUS: read {16'b0, count[7:0], 5'b0, overflow, full, empty}; write with wdata[2]=1 clears overflow.
  - 0x02 CYCLE: read counter; writes ignored.
  - 0x03 CYCLE_CLR: any write zeroes counter; read returns 0.
- Push accepted when memwrite to TX_DATA and (not full or pop this cycle). Rejected push drops data and sets overflow (sticky).
- Pop when tx_valid & tx_ready. tx_data = oldest entry; undefined-but-stable (hold last) when empty is not required; bench checks only when tx_valid.
- Overflow set and clear in same cycle: set wins (cannot happen by one core store; defined for completeness).
- count width clog2(FIFO_DEPTH)+1, zero-extended into status bits [15:8].

## Timing
- Reset values: tx_valid 0, FIFO count 0, read/write pointers 0, overflow 0, cycle counter 0; rdata follows addr (RAM part unreset).
- Load latency 0: rdata valid same cycle as addr. Store to RAM visible on rdata the cycle after the write edge; same-cycle read returns old word.
- Push latency 1: first push into empty FIFO raises tx_valid the next cycle.
- Simultaneous push+pop: count unchanged; when full both accepted, no overflow.
- Pointers wrap modulo FIFO_DEPTH.
- Cycle counter increments every cycle after reset deasserts, wraps 0xFFFFFFFF→0; CYCLE_CLR write → reads 0 the next cycle, 1 the one after. CYCLE_CLR has priority over increment.
- Reset mid-operation: FIFO emptied and flags cleared at that edge regardless of memwrite/tx_ready; in-flight store in reset cycle to MMIO is discarded, to RAM is still performed.

## Structure
- Shared package dmem_pkg: MMIO base 32'hFFFFFF00, offset constants TX_DATA/TX_STATUS/CYCLE/CYCLE_CLR, status bit positions.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, synchronous reset). Decode, RAM, counter and overflow logic live in dmem_mmio.

## Test plan
- Write 0xDEADBEEF to addr 5, then read addr 5 → rdata 0xDEADBEEF next cycle; same-cycle read returned prior value; read addr 0x00001000 → 0.
- Push 0x11,0x22,0x33 to 0xFFFFFF00 with tx_ready=0 → tx_valid=1, status=0x00000300; raise tx_ready → tx_data 0x11,0x22,0x33 on consecutive cycles, then tx_valid=0, status=0x00000001.
- Fill FIFO (4 pushes), push 0x55 with tx_ready=0 → 0x55 dropped, status=0x00000406; write 0x4 to status → status=0x00000402.
- FIFO full, tx_ready=1 and push 0x66 same cycle → no overflow, count stays 4, 0x66 emerges last.
- 10 cycles after reset CYCLE reads 10; write CYCLE_CLR → 0 next cycle, 1 following; force counter 0xFFFFFFFF → wraps to 0.
- Assert rst with 2 entries queued and overflow set → next cycle tx_valid=0, status=0x00000001, CYCLE=0.
